// File: rtl/spi_route_ctrl.sv
// Control-plane SPI slave (mode 0) decoding 2-byte command frames into the
// crossbar route-select and control registers, with ID/status readback.
module spi_route_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ROUTE_W       = 3,
  parameter int unsigned MAX_ROUTE     = 5,
  parameter int unsigned DEFAULT_ROUTE = 0,
  parameter logic [7:0]  ID_BYTE       = 8'hC5
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic               spi_sclk_i,
  input  logic               spi_mosi_i,
  input  logic               spi_ssel_i,
  output logic               spi_miso_o,
  output logic               spi_miso_oe_o,
  output logic [ROUTE_W-1:0] route_o,
  output logic               route_valid_o,
  output logic [7:0]         ctrl_o,
  output logic               cmd_stb_o,
  output logic               frame_err_o
);

  localparam logic [7:0] CMD_WR_ROUTE = 8'h01;
  localparam logic [7:0] CMD_WR_CTRL  = 8'h02;
  localparam logic [7:0] CMD_RD_ID    = 8'h80;
  localparam logic [7:0] CMD_RD_STAT  = 8'h81;
  localparam logic [ROUTE_W-1:0] MAX_R = ROUTE_W'(MAX_ROUTE);
  localparam logic [ROUTE_W-1:0] DEF_R = ROUTE_W'(DEFAULT_ROUTE);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, DATA, APPLY, DONE} state_t;

  function automatic logic cmd_legal(input logic [7:0] c);
    return (c == CMD_WR_ROUTE) || (c == CMD_WR_CTRL) || (c == CMD_RD_ID) || (c == CMD_RD_STAT);
  endfunction

  function automatic logic cmd_is_read(input logic [7:0] c);
    return (c == CMD_RD_ID) || (c == CMD_RD_STAT);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ssel_sync;
  logic sclk_s, mosi_s, ssel_s, sclk_d, ssel_d;
  logic sclk_rise, sclk_fall, ssel_rise, ssel_fall;

  state_t       state, state_n;
  logic [3:0]   bit_cnt;
  logic [15:0]  frame_sr;
  logic [7:0]   next_cmd, status, load_val, miso_sr;
  logic [ROUTE_W-1:0] route_q;
  logic [7:0]   ctrl_q;
  logic         valid_q, err_sticky, stb_q, err_q, oe_q, rd_active, miso_hold;
  logic         do_shift, cnt_clr, miso_load, err_n, stb_n, sticky_clr;
  logic         wr_route, route_ok;

  // Input synchronisers and edge detector; data path only, no reset.
  always_ff @(posedge clk_i) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
    ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], spi_ssel_i};
    sclk_d    <= sclk_s;
    ssel_d    <= ssel_s;
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ssel_rise = ssel_s & ~ssel_d;
  assign ssel_fall = ~ssel_s & ssel_d;

  assign next_cmd = {frame_sr[6:0], mosi_s};
  assign wr_route = (frame_sr[15:8] == CMD_WR_ROUTE);
  assign route_ok = (frame_sr[ROUTE_W-1:0] <= MAX_R);

  always_comb begin
    status = '0;
    status[ROUTE_W-1:0] = route_q;
    status[7] = valid_q;
    status[6] = err_sticky;
    load_val = (next_cmd == CMD_RD_STAT) ? status : ID_BYTE;
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) state <= WAIT_IDLE;
    else          state <= state_n;
  end

  // An ssel rise is checked before sclk so it wins a same-clk collision.
  always_comb begin
    state_n    = state;
    do_shift   = 1'b0;
    cnt_clr    = 1'b0;
    miso_load  = 1'b0;
    err_n      = 1'b0;
    stb_n      = 1'b0;
    sticky_clr = 1'b0;
    case (state)
      WAIT_IDLE: if (ssel_s) state_n = IDLE;
      IDLE: if (ssel_fall) begin
        state_n = CMD;
        cnt_clr = 1'b1;
      end
      CMD: begin
        if (ssel_rise) begin
          state_n = IDLE;
          err_n   = (bit_cnt != 4'd0);
        end else if (sclk_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == 4'd7) begin
            if (cmd_legal(next_cmd)) begin
              state_n   = DATA;
              miso_load = cmd_is_read(next_cmd);
            end else begin
              state_n = DONE;
              err_n   = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (ssel_rise) begin
          state_n = IDLE;
          err_n   = (bit_cnt[2:0] != 3'd0);
        end else if (sclk_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == 4'd15) state_n = APPLY;
        end
      end
      APPLY: begin
        state_n    = DONE;
        err_n      = wr_route & ~route_ok;
        stb_n      = (wr_route & route_ok) | (frame_sr[15:8] == CMD_WR_CTRL);
        sticky_clr = (frame_sr[15:8] == CMD_RD_STAT);
      end
      DONE: if (ssel_s) state_n = IDLE;
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      bit_cnt    <= '0;
      route_q    <= DEF_R;
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      err_sticky <= 1'b0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      oe_q       <= 1'b0;
      rd_active  <= 1'b0;
    end else begin
      oe_q  <= ~ssel_s;
      stb_q <= stb_n;
      err_q <= err_n;
      if (cnt_clr)       bit_cnt <= '0;
      else if (do_shift) bit_cnt <= bit_cnt + 4'd1;
      if (stb_n && wr_route) begin
        route_q <= frame_sr[ROUTE_W-1:0];
        valid_q <= 1'b1;
      end
      if (stb_n && !wr_route) ctrl_q <= frame_sr[7:0];
      if (err_n)           err_sticky <= 1'b1;
      else if (sticky_clr) err_sticky <= 1'b0;
      rd_active <= miso_load | (rd_active & (state_n == DATA));
    end
  end

  // The first fall after loading holds the MSB so the master samples it on rise 9.
  always_ff @(posedge clk_i) begin
    if (do_shift) frame_sr <= {frame_sr[14:0], mosi_s};
    if (miso_load) begin
      miso_sr   <= load_val;
      miso_hold <= 1'b1;
    end else if (sclk_fall && rd_active) begin
      if (miso_hold) miso_hold <= 1'b0;
      else           miso_sr   <= {miso_sr[6:0], 1'b0};
    end
  end

  assign spi_miso_o    = rd_active & miso_sr[7];
  assign spi_miso_oe_o = oe_q;
  assign route_o       = route_q;
  assign route_valid_o = valid_q;
  assign ctrl_o        = ctrl_q;
  assign cmd_stb_o     = stb_q;
  assign frame_err_o   = err_q;

endmodule
